// File: rtl/w1_trans_seq.sv
// Digit-serial transform: applies a per-digit 2-bit operation to A and B,
// L digits per cycle, building the result in w1 with a guard digit on top.
module w1_trans_seq #(
  parameter int unsigned P         = 33,
  parameter int unsigned L         = 4,
  parameter logic [1:0]  EXT_DIGIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [2*P-1:0]   a,
  input  logic [2*P-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*P+1:0]   w1,
  output logic             busy
);

  localparam int unsigned N  = (P + L - 1) / L;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*P-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [2*P+1:0]   w1_d;

  // Carry-free digit operation; 2-bit arithmetic wraps mod 4 naturally.
  function automatic logic [1:0] digit_op(input logic [1:0] m,
                                          input logic [1:0] x,
                                          input logic [1:0] y);
    case (m)
      2'd0:    digit_op = x + y;
      2'd1:    digit_op = x - y;
      2'd2:    digit_op = x * y;
      default: digit_op = (x > y) ? x : y;
    endcase
  endfunction

  // Next-state and datapath; digit i belongs to chunk i/L, so positions
  // beyond P in the last chunk simply do not exist.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    w1_d    = w1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          w1_d    = {EXT_DIGIT, {(2*P){1'b0}}};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(P); i++) begin
          if (cnt_q == CW'(i / int'(L)))
            w1_d[2*i +: 2] = digit_op(mode_q, a_q[2*i +: 2], b_q[2*i +: 2]);
        end
        if (cnt_q == CW'(N - 1)) state_d = DONE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      w1        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      w1        <= w1_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_w1_trans_seq.sv
// Bench for w1_trans_seq: a default (P=33,L=4) and a partial-chunk
// (P=5,L=2) instance checked against a digit-level reference model.
module tb_w1_trans_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  iv  = '0;
  logic [1:0]  orr = '0;
  logic [1:0]  md [2];
  logic [65:0] av [2];
  logic [65:0] bv [2];
  logic [1:0]  ir, ov, bz;
  logic [67:0] w_0;
  logic [11:0] w_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w1_trans_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mode(md[0]),
    .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .w1(w_0), .busy(bz[0])
  );

  w1_trans_seq #(.P(5), .L(2), .EXT_DIGIT(2'b01)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mode(md[1]),
    .a(av[1][9:0]), .b(bv[1][9:0]), .out_valid(ov[1]), .out_ready(orr[1]),
    .w1(w_1), .busy(bz[1])
  );

  typedef struct {
    int          sel;
    logic [1:0]  m;
    logic [65:0] a;
    logic [65:0] b;
    logic [67:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [67:0] wout(input int sel);
    return (sel != 0) ? {56'b0, w_1} : w_0;
  endfunction

  function automatic logic [65:0] rand66();
    return {2'($urandom), $urandom, $urandom};
  endfunction

  // Reference: per-digit result using integer arithmetic.
  function automatic logic [67:0] model(input int p, input logic [1:0] m,
                                        input logic [65:0] a_in,
                                        input logic [65:0] b_in);
    logic [67:0] r;
    int x, y, d;
    r = '0;
    for (int i = 0; i < p; i++) begin
      x = int'(a_in[2*i +: 2]);
      y = int'(b_in[2*i +: 2]);
      case (m)
        2'd0:    d = (x + y) % 4;
        2'd1:    d = (x - y + 4) % 4;
        2'd2:    d = (x * y) % 4;
        default: d = (x > y) ? x : y;
      endcase
      r[2*i +: 2] = 2'(d);
    end
    r[2*p +: 2] = 2'b01;
    return r;
  endfunction

  task automatic chk(input string name, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int sel, input logic [1:0] m,
                        input logic [65:0] a_in, input logic [65:0] b_in,
                        input logic [67:0] exp, input int hold);
    int lat, nn;
    nn = (sel != 0) ? 3 : 9;
    md[sel] = m; av[sel] = a_in; bv[sel] = b_in; iv[sel] = 1'b1;
    tick();
    iv[sel] = 1'b0;
    md[sel] = 2'($urandom); av[sel] = rand66(); bv[sel] = rand66();
    chk("busy_after_accept", 68'(bz[sel]), 68'd1);
    lat = 0;
    while (!ov[sel] && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", 68'(lat), 68'(nn));
    chk("w1_result", wout(sel), exp);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("w1_hold", wout(sel), exp);
      chk("ov_hold", 68'(ov[sel]), 68'd1);
    end
    orr[sel] = 1'b1;
    tick();
    orr[sel] = 1'b0;
    chk("idle_in_ready", 68'(ir[sel]), 68'd1);
    chk("ov_after_take", 68'(ov[sel]), 68'd0);
    chk("w1_kept", wout(sel), exp);
  endtask

  initial begin
    logic [67:0] e;
    logic [65:0] ra, rb;
    logic [1:0]  rm;
    int sel, bad;

    for (int s = 0; s < 2; s++) begin
      md[s] = '0; av[s] = '0; bv[s] = '0;
    end

    // Reset held two cycles with in_valid asserted: nothing is accepted.
    rst = 1'b1; iv = 2'b11;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_w1", wout(s), 68'd0);
      chk("rst_ov", 68'(ov[s]), 68'd0);
      chk("rst_busy", 68'(bz[s]), 68'd0);
      chk("rst_in_ready", 68'(ir[s]), 68'd1);
    end
    iv = 2'b00; rst = 1'b0;
    tick();

    tbl[0] = '{0, 2'd0, {33{2'b11}}, {33{2'b01}}, {2'b01, 66'b0}};
    tbl[1] = '{0, 2'd1, 66'b0, {33{2'b01}}, {2'b01, {66{1'b1}}}};
    tbl[2] = '{0, 2'd3, {33{2'b10}}, {33{2'b01}}, {2'b01, {33{2'b10}}}};
    tbl[3] = '{0, 2'd2, {33{2'b11}}, {33{2'b11}}, {2'b01, {33{2'b01}}}};
    tbl[4] = '{1, 2'd2, 66'b10_11_01_10_11, 66'b10_10_11_11_11,
               68'b01_00_10_11_10_01};
    for (int t = 0; t < 5; t++)
      run_op(tbl[t].sel, tbl[t].m, tbl[t].a, tbl[t].b, tbl[t].exp, t % 2);

    // Backpressure: DONE held with in_valid high and operands toggling.
    ra = rand66(); rb = rand66();
    e = model(33, 2'd1, ra, rb);
    md[0] = 2'd1; av[0] = ra; bv[0] = rb; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    bad = 0;
    while (!ov[0] && bad < 40) begin
      tick();
      bad++;
    end
    chk("bp_reach_done", 68'(ov[0]), 68'd1);
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1; av[0] = ~av[0]; bv[0] = ~bv[0]; md[0] = md[0] + 2'd1;
      tick();
      chk("bp_w1", w_0, e);
      chk("bp_in_ready", 68'(ir[0]), 68'd0);
      chk("bp_ov", 68'(ov[0]), 68'd1);
    end
    orr[0] = 1'b1;
    tick();
    orr[0] = 1'b0; iv[0] = 1'b0;
    chk("bp_idle_ready", 68'(ir[0]), 68'd1);
    chk("bp_no_accept", 68'(bz[0]), 68'd0);
    chk("bp_ov_low", 68'(ov[0]), 68'd0);
    chk("bp_w1_kept", w_0, e);
    tick();

    // Reset at chunk counter 4 discards the operation.
    md[0] = 2'd0; av[0] = rand66(); bv[0] = rand66(); iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    chk("mid_busy", 68'(bz[0]), 68'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready", 68'(ir[0]), 68'd1);
    chk("mid_w1", w_0, 68'd0);
    chk("mid_busy_low", 68'(bz[0]), 68'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ov[0] !== 1'b0) bad++;
    end
    chk("mid_no_ov", 68'(bad), 68'd0);

    // Randomised operations on both instances.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      rm = 2'($urandom); ra = rand66(); rb = rand66();
      e = model((sel != 0) ? 5 : 33, rm, ra, rb);
      run_op(sel, rm, ra, rb, e, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w1_trans_seq.md
W1_TRANS_SEQ -- requirements
Module: w1_trans_seq

Interface
REQ-001 The block SHALL have parameter P, default 33, meaning the operand length in four-valued digits, each digit 2 bits, digit i at bits [2i+1:2i].
REQ-002 The block SHALL have parameter L, default 4, meaning the digits processed per cycle; legal range 1 <= L <= P.
REQ-003 The block SHALL have parameter EXT_DIGIT, default 2'b01, meaning the guard digit written to w1[2P+1:2P].
REQ-004 Derived value N = ceil(P/L) SHALL be the number of RUN cycles per operation.
REQ-005 Ports SHALL be, one per line (name, direction, width, meaning); clock and reset are fixed as one clock plus a synchronous, active-high reset:
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous active-high reset
  in_valid  in  1  operand available
  in_ready  out  1  block can accept an operand
  mode  in  2  digit operation, sampled at acceptance
  a  in  2P  operand A
  b  in  2P  operand B
  out_valid  out  1  w1 holds a finished result
  out_ready  in  1  consumer takes the result
  w1  out  2P+2  result register
  busy  out  1  high in RUN or DONE

Function
REQ-006 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-007 in_ready SHALL be 1 only in IDLE.
REQ-008 busy SHALL equal (state != IDLE).
REQ-009 out_valid SHALL be 1 only in DONE.
REQ-010 An input handshake (in_valid & in_ready at an edge) SHALL do all of the following: latch a, b and mode internally; clear w1[2P-1:0] to 0; write EXT_DIGIT to w1[2P+1:2P]; reset the chunk counter to 0; go to RUN.
REQ-011 In RUN, each edge SHALL write digits [cL .. min(cL+L, P)-1] of w1, where c is the chunk counter, and then increment c.
REQ-012 Digit positions >= P in the last chunk SHALL be ignored; they are never read and never written.
REQ-013 After the edge that writes chunk N-1, the FSM SHALL enter DONE; a handshake at edge k therefore gives out_valid = 1 after edge k+N.
REQ-014 Digit operation per mode, with x = a_i and y = b_i as unsigned values 0..3:
  0 ADD: (x+y) mod 4
  1 SUB: (x-y) mod 4
  2 MUL: (x*y) mod 4
  3 MAX: max(x,y)
REQ-015 Digit operations SHALL be independent, with no inter-digit carry.
REQ-016 In DONE, w1 and out_valid SHALL hold stable until out_ready = 1.
REQ-017 On the output handshake edge, the FSM SHALL go to IDLE, and w1 SHALL keep its value.
REQ-018 in_valid SHALL be ignored while not in IDLE; changes to a, b or mode after acceptance SHALL have no effect on the operation in progress.
REQ-019 The minimum issue interval SHALL be N+2 cycles: accept at k, DONE after k+N, output handshake at k+N+1, next accept at k+N+2.
REQ-020 The FSM SHALL never accept a new operand in the same cycle as an output handshake.
REQ-021 w1 SHALL be registered, with no combinational path from a, b or mode to w1.

Reset
REQ-022 rst = 1 at an edge SHALL do all of the following: state IDLE, chunk counter 0, w1 = 0 (including the guard digit), out_valid 0, busy 0, in_ready 1 on the following cycle.
REQ-023 rst SHALL take priority over every handshake.
REQ-024 Reset during RUN or DONE SHALL discard the operation; no out_valid pulse follows.
REQ-025 While rst = 1, in_valid SHALL NOT be accepted.

Verification
REQ-026 Reset: hold rst for 2 cycles -> w1 = 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-027 ADD, P=33, L=4: all digits a = 3, b = 1, handshake at edge k -> out_valid after edge k+9; w1 = {2'b01, 66'b0}.
REQ-028 SUB: a = 0, b = all digits 1 -> w1 = {2'b01, 66 bits all 1}, i.e. every digit = 3.
REQ-029 Partial chunk, P=5, L=2, MUL: a digits (d0..d4) = 3,2,1,3,2 and b = 3,3,3,2,2 -> result digits 1,2,3,2,0; out_valid 3 edges after acceptance.
REQ-030 Backpressure: out_ready low for 5 cycles in DONE while in_valid = 1 and a, b toggling -> w1 unchanged, in_ready = 0, no new acceptance; out_ready = 1 -> IDLE next cycle.
REQ-031 Reset mid-run: rst at chunk counter 4 in a P=33 operation -> IDLE next cycle, w1 = 0; out_valid stays 0 for the following 20 cycles with in_valid low.
